// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory controller.
// Holds the controller state encoding, the NOP instruction and the default geometry.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // RV32I "addi x0, x0, 0"
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_AW    = 6;

endpackage

// File: rtl/imem_ctrl_if.sv
// Bundle of loader, fetch and memory-port signals between the controller and its neighbours.
// The slave modport is the controller's view; master is the view of the surrounding system.
interface imem_ctrl_if
  import imem_pkg::*;
#(
  parameter int AW = DEFAULT_AW
);

  // Loader handshake: a word is consumed in every cycle where ld_valid and
  // ld_ready are both high; ld_data and ld_last are only sampled in such a cycle.
  logic          ld_start;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_done;
  logic [AW:0]   ld_count;

  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic          core_hold;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;

  logic [1:0]    err;

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last,
    input  if_req, if_addr, mem_rdata,
    output ld_ready, ld_done, ld_count,
    output if_valid, if_instr, core_hold,
    output mem_we, mem_waddr, mem_wdata, mem_raddr,
    output err
  );

  modport master (
    output ld_start, ld_valid, ld_data, ld_last,
    output if_req, if_addr, mem_rdata,
    input  ld_ready, ld_done, ld_count,
    input  if_valid, if_instr, core_hold,
    input  mem_we, mem_waddr, mem_wdata, mem_raddr,
    input  err
  );

endinterface

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: streams a program into an external sync RAM,
// then serves single-cycle-latency pipelined instruction fetches from it.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic       clk,
  input  logic       rst_n,
  imem_ctrl_if.slave bus,
  output state_t     dbg_state
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);

  state_t      state_q;
  state_t      state_d;
  logic [AW:0] cnt_q;
  logic [1:0]  err_q;
  logic        valid_q;
  logic        nop_q;
  logic        done_q;

  logic        ready;
  logic        hold;
  logic        ld_hs;
  logic        fetch;
  logic        misaligned;
  logic        out_of_range;
  logic        load_entry;
  logic        load_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.ld_start) state_d = ST_LOAD;
      ST_LOAD:  if (ld_hs && (bus.ld_last || cnt_q == LAST_C)) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      ST_RUN:   if (bus.ld_start) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    hold  = 1'b1;
    fetch = 1'b0;
    case (state_q)
      ST_LOAD: ready = (cnt_q < DEPTH_C);
      ST_RUN: begin
        hold  = 1'b0;
        fetch = bus.if_req;
      end
      default: ;
    endcase
  end

  assign ld_hs        = bus.ld_valid & ready;
  assign misaligned   = |bus.if_addr[1:0];
  assign out_of_range = |bus.if_addr[31:AW+2];
  assign load_entry   = (state_q != ST_LOAD) && (state_d == ST_LOAD);
  assign load_exit    = (state_q == ST_LOAD) && (state_d == ST_FLUSH);

  // A fetch accepted in the same cycle as ld_start still completes; error
  // flags are wiped on load entry, which takes priority over a new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      nop_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= fetch;
      nop_q   <= fetch & (misaligned | out_of_range);
      done_q  <= load_exit;
      if (load_entry) begin
        cnt_q <= '0;
      end else if (ld_hs) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load_entry) begin
        err_q <= '0;
      end else if (fetch) begin
        err_q <= err_q | {out_of_range, misaligned};
      end
    end
  end

  assign bus.ld_ready  = ready;
  assign bus.ld_done   = done_q;
  assign bus.ld_count  = cnt_q;
  assign bus.core_hold = hold;
  assign bus.mem_we    = ld_hs;
  assign bus.mem_waddr = cnt_q[AW-1:0];
  assign bus.mem_wdata = bus.ld_data;
  assign bus.mem_raddr = bus.if_addr[AW+1:2];
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = nop_q ? NOP : bus.mem_rdata;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: program loads, pipelined fetches,
// error flags, reload with a fetch in flight, and reset during a load.
module tb_imem_ctrl;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NV    = 11;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  imem_ctrl_if #(.AW(AW)) bus ();

  imem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // external synchronous RAM
  logic [31:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_raddr];
  end

  // reference model and scoreboard
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] words   [128];
  logic [31:0] exp_q[$];
  logic [1:0]  m_err;
  bit          m_run;
  int          n_chk;
  int          n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_instr(input logic [31:0] a);
    if ((a % 4) != 0 || a >= 32'(DEPTH * 4)) return NOP;
    return ref_mem[a / 4];
  endfunction

  task automatic note_fetch(input logic req, input logic [31:0] a);
    if (req && m_run) begin
      exp_q.push_back(expect_instr(a));
      if ((a % 4) != 0) m_err[0] = 1'b1;
      if (a >= 32'(DEPTH * 4)) m_err[1] = 1'b1;
    end
  endtask

  task automatic check_resp_err();
    logic [31:0] e;
    check("if_valid", bus.if_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("if_instr", bus.if_instr, e);
    end
    check("err", bus.err, m_err);
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
  endtask

  task automatic fetch_cycle(input logic req, input logic [31:0] a);
    bus.if_req  = req;
    bus.if_addr = a;
    @(negedge clk);
    check_resp_err();
    check("core_hold", bus.core_hold, !m_run);
    check("mem_we_fetch", bus.mem_we, 1'b0);
    if (req) check("mem_raddr", bus.mem_raddr, a[AW+1:2]);
    note_fetch(req, a);
    @(posedge clk); #1;
  endtask

  task automatic random_fetches(input int ncyc);
    logic [31:0] a;
    int r;
    for (int k = 0; k < ncyc; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else             a = $urandom() | 32'h0000_0100;
      fetch_cycle($urandom_range(0, 3) != 0, a);
    end
    fetch_cycle(1'b0, 32'h0);
  endtask

  task automatic load(input int n, input bit use_last, input bit gaps,
                      input bit with_fetch, input logic [31:0] faddr);
    int  wr;
    int  seen;
    int  guard;
    bit  done;
    logic v;
    wr = 0; seen = 0; guard = 0; done = 0;
    bus.ld_start = 1'b1;
    bus.if_req   = with_fetch;
    bus.if_addr  = faddr;
    @(negedge clk);
    check_resp_err();
    check("start_hold", bus.core_hold, !m_run);
    check("start_ready", bus.ld_ready, 1'b0);
    note_fetch(with_fetch, faddr);
    m_err = 2'b00;
    m_run = 0;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    while (!done) begin
      guard++;
      if (guard > 2000) begin
        n_chk++; n_fail++;
        $display("FAIL load_timeout: got %0d words expected %0d", wr, n);
        break;
      end
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.ld_valid = v;
      bus.ld_data  = words[wr];
      bus.ld_last  = use_last && (wr == n - 1);
      bus.if_req   = $urandom_range(0, 1);
      bus.if_addr  = 32'($urandom_range(0, DEPTH - 1)) * 4;
      @(negedge clk);
      check_resp_err();
      check("load_ready", bus.ld_ready, 1'b1);
      check("load_hold", bus.core_hold, 1'b1);
      check("load_done", bus.ld_done, 1'b0);
      check("load_we", bus.mem_we, v);
      if (bus.mem_we) seen++;
      if (v) begin
        check("load_waddr", bus.mem_waddr, wr[AW-1:0]);
        check("load_wdata", bus.mem_wdata, words[wr]);
        ref_mem[wr] = words[wr];
        wr++;
        if ((use_last && wr == n) || wr == DEPTH) done = 1;
      end
      @(posedge clk); #1;
    end
    // flush cycle: surplus words and ld_start must both be ignored
    bus.ld_valid = (wr < n);
    bus.ld_data  = words[wr];
    bus.ld_last  = 1'b0;
    bus.ld_start = 1'b1;
    bus.if_req   = 1'b1;
    @(negedge clk);
    check_resp_err();
    check("flush_done", bus.ld_done, 1'b1);
    check("flush_hold", bus.core_hold, 1'b1);
    check("flush_ready", bus.ld_ready, 1'b0);
    check("flush_we", bus.mem_we, 1'b0);
    check("flush_count", bus.ld_count, wr);
    check("flush_state", dbg_state, ST_FLUSH);
    @(posedge clk); #1;
    m_run = 1;
    bus.ld_start = 1'b0;
    bus.if_req   = 1'b0;
    @(negedge clk);
    check_resp_err();
    check("run_done", bus.ld_done, 1'b0);
    check("run_hold", bus.core_hold, 1'b0);
    check("run_ready", bus.ld_ready, 1'b0);
    check("run_we", bus.mem_we, 1'b0);
    check("run_count", bus.ld_count, wr);
    check("load_writes", seen, (use_last && n < DEPTH) ? n : DEPTH);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    vec_t vec [NV];
    vec[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0050_0093};
    vec[1]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h0030_0113};
    vec[2]  = '{1'b1, 32'h0000_0008, 1'b1, 32'h0020_81B3};
    vec[3]  = '{1'b1, 32'h0000_000C, 1'b1, 32'h0000_006F};
    vec[4]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vec[5]  = '{1'b1, 32'h0000_0006, 1'b1, 32'h0000_0013};
    vec[6]  = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0013};
    vec[7]  = '{1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000};
    vec[8]  = '{1'b1, 32'h0000_0104, 1'b1, 32'h0000_0013};
    vec[9]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h0030_0113};
    vec[10] = '{1'b1, 32'h0000_0002, 1'b1, 32'h0000_0013};

    n_chk = 0; n_fail = 0; m_err = 2'b00; m_run = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    idle_inputs();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_hold", bus.core_hold, 1'b1);
    check("rst_ready", bus.ld_ready, 1'b0);
    check("rst_done", bus.ld_done, 1'b0);
    check("rst_count", bus.ld_count, 0);
    check("rst_err", bus.err, 2'b00);
    check("rst_valid", bus.if_valid, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fetch_cycle(1'b1, 32'h0);
    fetch_cycle(1'b0, 32'h0);

    // short program terminated by ld_last
    words[0] = 32'h0050_0093;
    words[1] = 32'h0030_0113;
    words[2] = 32'h0020_81B3;
    words[3] = 32'h0000_006F;
    load(4, 1, 0, 0, 32'h0);

    // back-to-back fetches and error cases from the vector table
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) begin
        bus.if_req  = vec[k].req;
        bus.if_addr = vec[k].addr;
      end else begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
      end
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("vec%0d_valid", k - 1), bus.if_valid, vec[k-1].exp_valid);
        if (vec[k-1].exp_valid) check($sformatf("vec%0d_instr", k - 1), bus.if_instr, vec[k-1].exp_instr);
      end
      @(posedge clk); #1;
    end
    m_err = 2'b11;
    check("err_sticky", bus.err, 2'b11);

    random_fetches(200);

    // reload from RUN with a fetch issued alongside ld_start
    for (int i = 0; i < 128; i++) words[i] = $urandom();
    load(10, 1, 1, 1, 32'h0000_0004);
    random_fetches(200);

    // over-long load saturates at DEPTH words
    for (int i = 0; i < 128; i++) words[i] = $urandom();
    load(70, 0, 0, 1, 32'h0000_0008);
    random_fetches(300);

    // reset in the middle of a load
    bus.ld_start = 1'b1;
    @(negedge clk);
    check_resp_err();
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    m_run = 0;
    m_err = 2'b00;
    for (int k = 0; k < 2; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = $urandom();
      @(negedge clk);
      check("abort_we", bus.mem_we, 1'b1);
      check("abort_waddr", bus.mem_waddr, k[AW-1:0]);
      ref_mem[k] = bus.ld_data;
      @(posedge clk); #1;
    end
    bus.ld_data = $urandom();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_ready", bus.ld_ready, 1'b0);
    check("abort_we_rst", bus.mem_we, 1'b0);
    check("abort_count", bus.ld_count, 0);
    check("abort_hold", bus.core_hold, 1'b1);
    check("abort_err", bus.err, 2'b00);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", bus.ld_done, 1'b0);
      check("abort_idle", dbg_state, ST_IDLE);
      @(posedge clk); #1;
    end

    // partially written words survive; a fresh load then runs normally
    for (int i = 0; i < 128; i++) words[i] = $urandom();
    load(3, 1, 1, 0, 32'h0);
    random_fetches(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
